// File: rtl/sv32_page_walker.sv
// sv32_page_walker: Sv32 hardware page-table walker behind the instruction TLB.
// It takes one TLB miss at a time and walks SATP -> level-1 PTE -> level-0 PTE.
// Each walk issues at most one memory read at a time. The walk ends with a
// leaf PTE on the refill port or with an instruction page fault.
// Ports:
//   CLK, RSTN              clock, asynchronous active-low reset
//   SATP                   bit31 = Sv32 enable, [PPN_LEN-1:0] = root PPN
//   WALK_FLUSH             abort the walk in flight
//   WALK_REQ_VALID/VADDR   miss request (accepted only when idle)
//   WALK_BUSY              high whenever a walk or a drain is in progress
//   PTE_VALID/PTE_OUT      one-cycle refill pulse and the leaf PTE, which holds
//   PAGE_FAULT/FAULT_VADDR one-cycle fault pulse and the faulting VA, which holds
//   MEM_REQ_*              PTE read request (valid/ready)
//   MEM_RESP_*             PTE read response
module sv32_page_walker #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned PPN_LEN           = 22,
  parameter int unsigned VPN_LEN           = 10,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned PTESIZE           = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [31:0]           SATP,
  input  logic                  WALK_FLUSH,
  input  logic                  WALK_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] WALK_REQ_VADDR,
  output logic                  WALK_BUSY,
  output logic                  PTE_VALID,
  output logic [DATA_WIDTH-1:0] PTE_OUT,
  output logic                  PAGE_FAULT,
  output logic [ADDR_WIDTH-1:0] FAULT_VADDR,
  output logic                  MEM_REQ_VALID,
  output logic [ADDR_WIDTH-1:0] MEM_REQ_ADDR,
  input  logic                  MEM_REQ_READY,
  input  logic                  MEM_RESP_VALID,
  input  logic [DATA_WIDTH-1:0] MEM_RESP_DATA
);

  localparam int unsigned PTE_SHIFT   = $clog2(PTESIZE);
  localparam int unsigned PA_W        = PPN_LEN + PAGE_OFFSET_WIDTH;
  localparam int unsigned PTE_PPN_LSB = 10;
  localparam int unsigned VPN0_LSB    = PAGE_OFFSET_WIDTH;
  localparam int unsigned VPN1_LSB    = PAGE_OFFSET_WIDTH + VPN_LEN;
  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_A = 6;

  typedef enum logic [3:0] {
    ST_IDLE, ST_BARE, ST_L1_REQ, ST_L1_WAIT, ST_L0_REQ, ST_L0_WAIT,
    ST_DONE, ST_FAULT, ST_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   vaddr_q, vaddr_d;
  logic [PPN_LEN-1:0]      ppn_q, ppn_d;
  logic                    busy_d, pte_valid_d, page_fault_d, req_valid_d;
  logic [DATA_WIDTH-1:0]   pte_out_d;
  logic [ADDR_WIDTH-1:0]   fault_vaddr_d, req_addr_d;

  // Reserved/ASID SATP bits play no part in the walk.
  logic unused_satp;
  assign unused_satp = ^SATP[30:PPN_LEN];

  // PTE physical address {ppn, vpn, 00}, truncated to the request bus width.
  function automatic logic [ADDR_WIDTH-1:0] pte_addr(input logic [PPN_LEN-1:0] ppn,
                                                     input logic [VPN_LEN-1:0] vpn);
    logic [PA_W-1:0] pa;
    pa = {ppn, PAGE_OFFSET_WIDTH'(0)} | (PA_W'(vpn) << PTE_SHIFT);
    return ADDR_WIDTH'(pa);
  endfunction

  // Response decode, shared by both levels.
  logic resp_bad, resp_leaf, resp_bad_leaf, resp_misaligned;
  logic [VPN_LEN-1:0] vpn0;
  assign vpn0            = vaddr_q[VPN0_LSB +: VPN_LEN];
  assign resp_bad        = !MEM_RESP_DATA[PTE_V] || (!MEM_RESP_DATA[PTE_R] && MEM_RESP_DATA[PTE_W]);
  assign resp_leaf       = MEM_RESP_DATA[PTE_R] || MEM_RESP_DATA[PTE_X];
  assign resp_bad_leaf   = !MEM_RESP_DATA[PTE_X] || !MEM_RESP_DATA[PTE_A];
  assign resp_misaligned = |MEM_RESP_DATA[PTE_PPN_LSB +: VPN_LEN];

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= ST_IDLE;
      vaddr_q       <= '0;
      ppn_q         <= '0;
      WALK_BUSY     <= 1'b0;
      PTE_VALID     <= 1'b0;
      PTE_OUT       <= '0;
      PAGE_FAULT    <= 1'b0;
      FAULT_VADDR   <= '0;
      MEM_REQ_VALID <= 1'b0;
      MEM_REQ_ADDR  <= '0;
    end else begin
      state_q       <= state_d;
      vaddr_q       <= vaddr_d;
      ppn_q         <= ppn_d;
      WALK_BUSY     <= busy_d;
      PTE_VALID     <= pte_valid_d;
      PTE_OUT       <= pte_out_d;
      PAGE_FAULT    <= page_fault_d;
      FAULT_VADDR   <= fault_vaddr_d;
      MEM_REQ_VALID <= req_valid_d;
      MEM_REQ_ADDR  <= req_addr_d;
    end
  end

  // Next state and next output values; result pulses are raised on the
  // transition into DONE/FAULT so they appear together with that state.
  always_comb begin
    state_d       = state_q;
    vaddr_d       = vaddr_q;
    ppn_d         = ppn_q;
    pte_out_d     = PTE_OUT;
    fault_vaddr_d = FAULT_VADDR;
    req_addr_d    = MEM_REQ_ADDR;
    pte_valid_d   = 1'b0;
    page_fault_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (WALK_REQ_VALID) begin
          vaddr_d = WALK_REQ_VADDR;
          ppn_d   = SATP[PPN_LEN-1:0];
          if (SATP[31]) begin
            state_d    = ST_L1_REQ;
            req_addr_d = pte_addr(SATP[PPN_LEN-1:0], WALK_REQ_VADDR[VPN1_LSB +: VPN_LEN]);
          end else begin
            state_d = ST_BARE;
          end
        end
      end
      ST_BARE: begin
        if (WALK_FLUSH) begin
          state_d = ST_IDLE;
        end else begin
          state_d     = ST_DONE;
          pte_valid_d = 1'b1;
          pte_out_d   = DATA_WIDTH'({vaddr_q[ADDR_WIDTH-1:PAGE_OFFSET_WIDTH], 10'h0CF});
        end
      end
      ST_L1_REQ, ST_L0_REQ: begin
        // A flush in the transfer cycle still launches the read, so drain it.
        if (MEM_REQ_VALID && MEM_REQ_READY) begin
          if (WALK_FLUSH)               state_d = ST_DRAIN;
          else if (state_q == ST_L1_REQ) state_d = ST_L1_WAIT;
          else                          state_d = ST_L0_WAIT;
        end else if (WALK_FLUSH) begin
          state_d = ST_IDLE;
        end
      end
      ST_L1_WAIT: begin
        if (WALK_FLUSH) begin
          state_d = MEM_RESP_VALID ? ST_IDLE : ST_DRAIN;
        end else if (MEM_RESP_VALID) begin
          if (resp_bad || (resp_leaf && (resp_misaligned || resp_bad_leaf))) begin
            state_d       = ST_FAULT;
            page_fault_d  = 1'b1;
            fault_vaddr_d = vaddr_q;
          end else if (resp_leaf) begin
            // Megapage: the low PPN slice comes from the VA.
            state_d     = ST_DONE;
            pte_valid_d = 1'b1;
            pte_out_d   = {MEM_RESP_DATA[DATA_WIDTH-1:PTE_PPN_LSB+VPN_LEN], vpn0,
                           MEM_RESP_DATA[PTE_PPN_LSB-1:0]};
          end else begin
            state_d    = ST_L0_REQ;
            ppn_d      = MEM_RESP_DATA[PTE_PPN_LSB +: PPN_LEN];
            req_addr_d = pte_addr(ppn_d, vpn0);
          end
        end
      end
      ST_L0_WAIT: begin
        if (WALK_FLUSH) begin
          state_d = MEM_RESP_VALID ? ST_IDLE : ST_DRAIN;
        end else if (MEM_RESP_VALID) begin
          if (resp_bad || !resp_leaf || resp_bad_leaf) begin
            state_d       = ST_FAULT;
            page_fault_d  = 1'b1;
            fault_vaddr_d = vaddr_q;
          end else begin
            state_d     = ST_DONE;
            pte_valid_d = 1'b1;
            pte_out_d   = MEM_RESP_DATA;
          end
        end
      end
      ST_DRAIN: begin
        if (MEM_RESP_VALID) state_d = ST_IDLE;
      end
      ST_DONE, ST_FAULT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_valid_d = (state_d == ST_L1_REQ) || (state_d == ST_L0_REQ);
    busy_d      = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_sv32_page_walker.sv
// Directed self-checking bench for sv32_page_walker.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_sv32_page_walker;
  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] SATP;
  logic        WALK_FLUSH, WALK_REQ_VALID;
  logic [31:0] WALK_REQ_VADDR;
  logic        WALK_BUSY, PTE_VALID, PAGE_FAULT, MEM_REQ_VALID;
  logic [31:0] PTE_OUT, FAULT_VADDR, MEM_REQ_ADDR;
  logic        MEM_REQ_READY, MEM_RESP_VALID;
  logic [31:0] MEM_RESP_DATA;

  int n_cmp = 0;
  int n_err = 0;

  sv32_page_walker dut (
    .CLK(CLK), .RSTN(RSTN), .SATP(SATP), .WALK_FLUSH(WALK_FLUSH),
    .WALK_REQ_VALID(WALK_REQ_VALID), .WALK_REQ_VADDR(WALK_REQ_VADDR),
    .WALK_BUSY(WALK_BUSY), .PTE_VALID(PTE_VALID), .PTE_OUT(PTE_OUT),
    .PAGE_FAULT(PAGE_FAULT), .FAULT_VADDR(FAULT_VADDR),
    .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_ADDR(MEM_REQ_ADDR),
    .MEM_REQ_READY(MEM_REQ_READY), .MEM_RESP_VALID(MEM_RESP_VALID),
    .MEM_RESP_DATA(MEM_RESP_DATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] satp, input logic [31:0] va);
    SATP = satp; WALK_REQ_VADDR = va; WALK_REQ_VALID = 1'b1;
    step();
    WALK_REQ_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; SATP = '0; WALK_FLUSH = 1'b0; WALK_REQ_VALID = 1'b0;
    WALK_REQ_VADDR = '0; MEM_REQ_READY = 1'b0; MEM_RESP_VALID = 1'b0; MEM_RESP_DATA = '0;
    #2;
    n_cmp++;
    if ({WALK_BUSY, PTE_VALID, PAGE_FAULT, MEM_REQ_VALID} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 0000", {WALK_BUSY, PTE_VALID, PAGE_FAULT, MEM_REQ_VALID});
    end
    n_cmp++;
    if ({PTE_OUT, FAULT_VADDR, MEM_REQ_ADDR} !== 96'h0) begin
      n_err++; $display("FAIL reset_data: got %h %h %h required zeros", PTE_OUT, FAULT_VADDR, MEM_REQ_ADDR);
    end
    step(); step();
    RSTN = 1'b1;
    step();
  endtask

  task automatic test_bare();
    issue(32'h0000_0000, 32'h8000_3ABC);
    n_cmp++;
    if ({WALK_BUSY, MEM_REQ_VALID, PTE_VALID} !== 3'b100) begin
      n_err++; $display("FAIL bare_accept: busy/req/pte got %b required 100", {WALK_BUSY, MEM_REQ_VALID, PTE_VALID});
    end
    step();
    n_cmp++;
    if (PTE_VALID !== 1'b1 || PTE_OUT !== 32'h2000_0CCF || MEM_REQ_VALID !== 1'b0) begin
      n_err++; $display("FAIL bare_pte: valid %b pte %h req %b required 1 20000ccf 0", PTE_VALID, PTE_OUT, MEM_REQ_VALID);
    end
    step();
    n_cmp++;
    if (PTE_VALID !== 1'b0 || WALK_BUSY !== 1'b0 || PTE_OUT !== 32'h2000_0CCF) begin
      n_err++; $display("FAIL bare_end: valid %b busy %b pte %h required 0 0 20000ccf", PTE_VALID, WALK_BUSY, PTE_OUT);
    end
  endtask

  task automatic test_walk_4k();
    MEM_REQ_READY = 1'b1;
    issue(32'h8000_0100, 32'h0040_1234);
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b1 || MEM_REQ_ADDR !== 32'h0010_0004) begin
      n_err++; $display("FAIL walk_l1_req: valid %b addr %h required 1 00100004", MEM_REQ_VALID, MEM_REQ_ADDR);
    end
    step();
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b0) begin
      n_err++; $display("FAIL walk_l1_req_drop: valid %b required 0", MEM_REQ_VALID);
    end
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0000_0801;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b1 || MEM_REQ_ADDR !== 32'h0000_2004) begin
      n_err++; $display("FAIL walk_l0_req: valid %b addr %h required 1 00002004", MEM_REQ_VALID, MEM_REQ_ADDR);
    end
    step();
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0123_404B;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (PTE_VALID !== 1'b1 || PTE_OUT !== 32'h0123_404B || PAGE_FAULT !== 1'b0) begin
      n_err++; $display("FAIL walk_pte: valid %b pte %h fault %b required 1 0123404b 0", PTE_VALID, PTE_OUT, PAGE_FAULT);
    end
    step();
    n_cmp++;
    if (PTE_VALID !== 1'b0 || WALK_BUSY !== 1'b0) begin
      n_err++; $display("FAIL walk_end: valid %b busy %b required 0 0", PTE_VALID, WALK_BUSY);
    end
  endtask

  task automatic test_megapage();
    MEM_REQ_READY = 1'b1;
    issue(32'h8000_0100, 32'h0040_1234);
    step();
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h2000_00CB;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (PTE_VALID !== 1'b1 || PTE_OUT !== 32'h2000_04CB || MEM_REQ_VALID !== 1'b0) begin
      n_err++; $display("FAIL mega_pte: valid %b pte %h req %b required 1 200004cb 0", PTE_VALID, PTE_OUT, MEM_REQ_VALID);
    end
    step();
    n_cmp++;
    if (PTE_VALID !== 1'b0 || WALK_BUSY !== 1'b0 || MEM_REQ_VALID !== 1'b0) begin
      n_err++; $display("FAIL mega_end: valid %b busy %b req %b required 0 0 0", PTE_VALID, WALK_BUSY, MEM_REQ_VALID);
    end
  endtask

  task automatic test_faults();
    logic [31:0] l1_data [3];
    logic [31:0] l0_data [3];
    logic [31:0] held_pte;
    l1_data = '{32'h2000_04CB, 32'h0000_0000, 32'h0000_0801};
    l0_data = '{32'h0,         32'h0,         32'h0123_4043};
    held_pte = 32'h2000_04CB;
    MEM_REQ_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h8000_0100, 32'h0040_1234);
      step();
      MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = l1_data[i];
      step();
      MEM_RESP_VALID = 1'b0;
      if (i == 2) begin
        step();
        MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = l0_data[i];
        step();
        MEM_RESP_VALID = 1'b0;
      end
      n_cmp++;
      if (PAGE_FAULT !== 1'b1 || FAULT_VADDR !== 32'h0040_1234 || PTE_VALID !== 1'b0 || PTE_OUT !== held_pte) begin
        n_err++; $display("FAIL fault_%0d: fault %b va %h valid %b pte %h required 1 00401234 0 %h",
                          i, PAGE_FAULT, FAULT_VADDR, PTE_VALID, PTE_OUT, held_pte);
      end
      step();
      n_cmp++;
      if (PAGE_FAULT !== 1'b0 || WALK_BUSY !== 1'b0 || FAULT_VADDR !== 32'h0040_1234) begin
        n_err++; $display("FAIL fault_end_%0d: fault %b busy %b va %h required 0 0 00401234", i, PAGE_FAULT, WALK_BUSY, FAULT_VADDR);
      end
    end
  endtask

  task automatic test_backpressure();
    MEM_REQ_READY = 1'b0;
    issue(32'h8000_0100, 32'h0040_1234);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (MEM_REQ_VALID !== 1'b1 || MEM_REQ_ADDR !== 32'h0010_0004) begin
        n_err++; $display("FAIL stall_%0d: valid %b addr %h required 1 00100004", i, MEM_REQ_VALID, MEM_REQ_ADDR);
      end
      if (i == 2) begin
        SATP = 32'h0000_0000; WALK_REQ_VADDR = 32'h1234_5678; WALK_REQ_VALID = 1'b1;
      end else begin
        SATP = 32'h8000_0100; WALK_REQ_VALID = 1'b0;
      end
      step();
    end
    WALK_REQ_VALID = 1'b0;
    MEM_REQ_READY = 1'b1;
    step();
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b0 || WALK_BUSY !== 1'b1) begin
      n_err++; $display("FAIL stall_release: valid %b busy %b required 0 1", MEM_REQ_VALID, WALK_BUSY);
    end
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0000_0801;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b1 || MEM_REQ_ADDR !== 32'h0000_2004) begin
      n_err++; $display("FAIL stall_l0_req: valid %b addr %h required 1 00002004", MEM_REQ_VALID, MEM_REQ_ADDR);
    end
    step();
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0123_404B;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (PTE_VALID !== 1'b1 || PTE_OUT !== 32'h0123_404B) begin
      n_err++; $display("FAIL stall_pte: valid %b pte %h required 1 0123404b", PTE_VALID, PTE_OUT);
    end
    step(); step();
    n_cmp++;
    if (WALK_BUSY !== 1'b0 || MEM_REQ_VALID !== 1'b0 || PTE_VALID !== 1'b0) begin
      n_err++; $display("FAIL stall_no_second: busy %b req %b valid %b required 0 0 0", WALK_BUSY, MEM_REQ_VALID, PTE_VALID);
    end
  endtask

  task automatic test_flush();
    MEM_REQ_READY = 1'b1;
    issue(32'h8000_0100, 32'h0040_1234);
    step();
    WALK_FLUSH = 1'b1;
    step();
    WALK_FLUSH = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (WALK_BUSY !== 1'b1 || MEM_REQ_VALID !== 1'b0 || PTE_VALID !== 1'b0) begin
        n_err++; $display("FAIL flush_drain_%0d: busy %b req %b valid %b required 1 0 0", i, WALK_BUSY, MEM_REQ_VALID, PTE_VALID);
      end
      step();
    end
    n_cmp++;
    if (WALK_BUSY !== 1'b1) begin
      n_err++; $display("FAIL flush_busy_hold: busy %b required 1", WALK_BUSY);
    end
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h0000_0801;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (WALK_BUSY !== 1'b0 || MEM_REQ_VALID !== 1'b0 || PTE_VALID !== 1'b0) begin
      n_err++; $display("FAIL flush_drained: busy %b req %b valid %b required 0 0 0", WALK_BUSY, MEM_REQ_VALID, PTE_VALID);
    end
    step();
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b0 || PAGE_FAULT !== 1'b0 || PTE_VALID !== 1'b0) begin
      n_err++; $display("FAIL flush_quiet: req %b fault %b valid %b required 0 0 0", MEM_REQ_VALID, PAGE_FAULT, PTE_VALID);
    end
    // A fresh megapage walk after the drain must complete normally.
    issue(32'h8000_0100, 32'h0040_1234);
    n_cmp++;
    if (MEM_REQ_VALID !== 1'b1 || MEM_REQ_ADDR !== 32'h0010_0004) begin
      n_err++; $display("FAIL flush_next_req: valid %b addr %h required 1 00100004", MEM_REQ_VALID, MEM_REQ_ADDR);
    end
    step();
    MEM_RESP_VALID = 1'b1; MEM_RESP_DATA = 32'h2000_00CB;
    step();
    MEM_RESP_VALID = 1'b0;
    n_cmp++;
    if (PTE_VALID !== 1'b1 || PTE_OUT !== 32'h2000_04CB) begin
      n_err++; $display("FAIL flush_next_pte: valid %b pte %h required 1 200004cb", PTE_VALID, PTE_OUT);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_bare();
    test_walk_4k();
    test_megapage();
    test_faults();
    test_backpressure();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
